aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Round sequencer for the iterative AES core. Accepts one block request at a time via valid/ready.
//  Waits for the key schedule (aes_kexp) to report ready, then steps the round-key index and
//  datapath controls through Nr+1 rounds (Nr = 10/12/14 for AES-128/192/256).
//  Presents a done handshake when finished. Sits between the host interface, the key schedule
//  and the S-box/MixColumns datapath.
// PARAMETERS
//  RK_IDX_W   4    width of round-key index and round counter (must hold 14)
//  NR_128     10   round count for klen=0
//  NR_192     12   round count for klen=1
//  NR_256     14   round count for klen=2
// PORTS
//  clk        in   1         single clock; all state changes on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         block request valid
//  in_ready   out  1         request accepted when in_valid&in_ready
//  in_klen    in   2         key length 0=128, 1=192, 2=256, 3=illegal; sampled at accept
//  in_dec     in   1         1=decrypt; sampled at accept
//  key_ready  in   1         key schedule holds valid expanded key
//  rk_idx     out  RK_IDX_W  round-key index to key schedule
//  dp_load    out  1         datapath: load input block, XOR rk_idx key (round 0)
//  dp_en      out  1         datapath: state register enable
//  dp_mix     out  1         datapath: apply (Inv)MixColumns this round
//  dp_inv     out  1         datapath: inverse ops (IBox, InvShift, InvMix)
//  rnd        out  RK_IDX_W  current round number 0..Nr
//  busy       out  1         high in any state except IDLE
//  out_valid  out  1         result block valid; held until out_ready
//  out_ready  in   1         consumer accepts result
//  err        out  1         one-cycle pulse: request with in_klen=3 rejected
// BEHAVIOUR
//  - All outputs are registered/Moore-decoded. After reset: state=IDLE; rk_idx=0, rnd=0; all flags 0.
//  - in_ready = (state==IDLE) & key_ready & ~rst. No new request is accepted in DONE; no overlap.
//  - States: IDLE -> LOAD -> ROUND -> FINAL -> DONE -> IDLE.
//    - IDLE: on accept with klen<=2: latch Nr and dec, go to LOAD.
//      On accept with klen=3: err=1 for the next cycle; stay in IDLE.
//    - LOAD (rnd=0): dp_load=1, dp_en=1, dp_mix=0. Go to ROUND.
//    - ROUND (rnd=1..Nr-1): dp_en=1, dp_mix=1; rnd increments each cycle; at rnd=Nr-1 go to FINAL.
//    - FINAL (rnd=Nr): dp_en=1, dp_mix=0. Go to DONE.
//    - DONE: out_valid=1, dp_en=0. When out_ready=1, go to IDLE (out_valid low the next cycle).
//  - rk_idx = rnd for encrypt; rk_idx = Nr-rnd for decrypt. dp_inv = latched dec.
//  - Latency: out_valid is first high Nr+2 rising edges after the accept edge (AES-128: 12).
//    Throughput is one block per Nr+3 cycles when out_ready is tied high.
//  - key_ready is checked only at accept. If it drops mid-operation the block completes with
//    the key held by the schedule; the key schedule must not change the key while busy.
//  - in_klen/in_dec changes after accept have no effect.
//  - rst mid-operation: next cycle is IDLE with all outputs at reset values; the block in
//    flight is dropped and no out_valid is produced.
//  - Counter arithmetic is unsigned RK_IDX_W bits and never exceeds Nr; no wrap.
// CONFIGURATION
//  - Macro AES_DECRYPT_EN.
//  - Defined: in_dec is honoured (reversed rk_idx, dp_inv=1).
//  - Undefined: in_dec is ignored and the latched dec is forced to 0; dp_inv is tied 0;
//    rk_idx always equals rnd. Ports are unchanged.
// STRUCTURE
//  - aes_const: NR_128/NR_192/NR_256 localparams, KLEN_ILLEGAL=2'd3.
//  - aes_wire: typedef enum logic[2:0] ctrl_state_t {IDLE,LOAD,ROUND,FINAL,DONE};
//    typedef struct ctrl_dp_t {load,en,mix,inv} to bundle the datapath controls.
//  - One sub-module, aes_nr_lut: combinational klen -> Nr and illegal flag. Everything else in one FSM.
// TESTING
//  1. rst=1 for 2 cycles -> in_ready=0, busy=0, out_valid=0, rk_idx=0.
//     Release with key_ready=1 -> in_ready=1 next cycle.
//  2. klen=0, dec=0, out_ready=1 -> rk_idx sequence 0,1..10; dp_mix=0 at rnd 0 and 10;
//     out_valid 12 edges after accept; datapath output matches FIPS-197 C.1.
//  3. klen=2, dec=1 (AES_DECRYPT_EN) -> rk_idx sequence 14,13..0; dp_inv=1; out_valid 16 edges after accept.
//  4. klen=3 -> err pulses once; busy stays 0; in_ready stays high.
//  5. out_ready=0 for 5 cycles in DONE -> out_valid held and in_ready=0 throughout;
//     out_ready=1 -> IDLE next cycle.
//  6. rst asserted at rnd=5 of a klen=1 block -> IDLE and all outputs 0 next cycle; no out_valid ever.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants and types for the AES round sequencer: round counts,
// the illegal key-length code, FSM state encoding and datapath control bundle.
package aes_round_ctrl_pkg;

    localparam int unsigned RK_IDX_W = 4;

    localparam logic [RK_IDX_W-1:0] NR_128 = 4'd10;
    localparam logic [RK_IDX_W-1:0] NR_192 = 4'd12;
    localparam logic [RK_IDX_W-1:0] NR_256 = 4'd14;

    localparam logic [1:0] KLEN_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    typedef struct packed {
        logic load;
        logic en;
        logic mix;
        logic inv;
    } ctrl_dp_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host-side request/result bundle of the AES round sequencer.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// the source holds valid and its payload stable until that edge.
interface aes_round_ctrl_if;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_klen;
    logic       in_dec;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    modport master (
        output in_valid, in_klen, in_dec, out_ready,
        input  in_ready, out_valid, err
    );

    modport slave (
        input  in_valid, in_klen, in_dec, out_ready,
        output in_ready, out_valid, err
    );

endinterface

// File: rtl/aes_nr_lut.sv
// Key length to AES round count decoder; flags the reserved key-length code.
module aes_nr_lut
    import aes_round_ctrl_pkg::*;
(
    input  logic [1:0]          klen_i,
    output logic [RK_IDX_W-1:0] nr_o,
    output logic                illegal_o
);

    always_comb begin
        nr_o      = NR_128;
        illegal_o = 1'b0;
        case (klen_i)
            2'd0:         nr_o = NR_128;
            2'd1:         nr_o = NR_192;
            2'd2:         nr_o = NR_256;
            KLEN_ILLEGAL: illegal_o = 1'b1;
            default:      illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: IDLE -> LOAD -> ROUND -> FINAL -> DONE.
// Build macro AES_DECRYPT_EN enables decryption (reversed key order, inverse datapath ops).
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    aes_round_ctrl_if.slave     host,
    input  logic                key_ready,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                dp_load,
    output logic                dp_en,
    output logic                dp_mix,
    output logic                dp_inv,
    output logic [RK_IDX_W-1:0] rnd,
    output logic                busy,
    output ctrl_state_t         dbg_state
);

    localparam logic [RK_IDX_W-1:0] ONE = 1;

    ctrl_state_t         state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [RK_IDX_W-1:0] nr_q, nr_d;
    logic                dec_q, dec_d;
    logic                err_q, err_d;

    logic [RK_IDX_W-1:0] lut_nr;
    logic                lut_illegal;
    logic                accept;
    logic                req_dec;
    ctrl_dp_t            dp;

    aes_nr_lut u_nr_lut (
        .klen_i    (host.in_klen),
        .nr_o      (lut_nr),
        .illegal_o (lut_illegal)
    );

`ifdef AES_DECRYPT_EN
    assign req_dec = host.in_dec;
`else
    assign req_dec = 1'b0;
`endif

    // rst gates ready so nothing can be accepted on the reset edge itself.
    assign host.in_ready = (state_q == IDLE) & key_ready & ~rst;
    assign accept        = host.in_valid & host.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lut_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        nr_d    = lut_nr;
                        dec_d   = req_dec;
                        rnd_d   = '0;
                    end
                end
            end
            LOAD: begin
                state_d = ROUND;
                rnd_d   = ONE;
            end
            ROUND: begin
                rnd_d = rnd_q + ONE;
                if (rnd_q == nr_q - ONE) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                if (host.out_ready) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = '0;
            end
        endcase
    end

    always_comb begin
        dp             = '0;
        host.out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                dp.load = 1'b1;
                dp.en   = 1'b1;
            end
            ROUND: begin
                dp.en  = 1'b1;
                dp.mix = 1'b1;
            end
            FINAL: begin
                dp.en = 1'b1;
            end
            DONE: begin
                host.out_valid = 1'b1;
            end
            default: ;
        endcase
        dp.inv = (state_q != IDLE) & dec_q;
        // Decryption consumes the expanded key schedule from the last round key back.
        if (state_q == IDLE) begin
            rk_idx = '0;
        end else if (dec_q) begin
            rk_idx = nr_q - rnd_q;
        end else begin
            rk_idx = rnd_q;
        end
    end

    assign host.err = err_q;
    assign dp_load  = dp.load;
    assign dp_en    = dp.en;
    assign dp_mix   = dp.mix;
    assign dp_inv   = dp.inv;
    assign rnd      = rnd_q;
    assign busy     = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: reset, full blocks per key length,
// illegal key length, result back-pressure and mid-block reset.
module tb_aes_round_ctrl;
  import aes_round_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                key_ready = 1'b0;
  logic [RK_IDX_W-1:0] rk_idx;
  logic                dp_load, dp_en, dp_mix, dp_inv;
  logic [RK_IDX_W-1:0] rnd;
  logic                busy;
  ctrl_state_t         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RK_IDX_W-1:0] exp_q[$];

`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  aes_round_ctrl_if hif();

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif),
    .key_ready (key_ready),
    .rk_idx    (rk_idx),
    .dp_load   (dp_load),
    .dp_en     (dp_en),
    .dp_mix    (dp_mix),
    .dp_inv    (dp_inv),
    .rnd       (rnd),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block request and checks every round, latency and the DONE handshake.
  task automatic run_block(input logic [1:0] klen, input logic dec, input int nr,
                           input int stall, input bit drop_key);
    int edges;
    int r;
    logic eff_dec;
    logic [RK_IDX_W-1:0] exp_rk;
    eff_dec = dec & DEC_EN;
    exp_q.delete();
    for (int i = 0; i <= nr; i++) exp_q.push_back(eff_dec ? RK_IDX_W'(nr - i) : RK_IDX_W'(i));
    hif.out_ready = (stall == 0);
    hif.in_klen   = klen;
    hif.in_dec    = dec;
    hif.in_valid  = 1'b1;
    check("ready_before_accept", hif.in_ready, 1);
    tick();
    hif.in_valid = 1'b0;
    hif.in_klen  = ~klen;
    hif.in_dec   = ~dec;
    if (drop_key) key_ready = 1'b0;
    edges = 1;
    r = 0;
    while (hif.out_valid !== 1'b1 && edges < 40) begin
      if (r <= nr) begin
        exp_rk = exp_q.pop_front();
        check($sformatf("k%0d_rnd%0d", klen, r), rnd, r);
        check($sformatf("k%0d_rk_idx%0d", klen, r), rk_idx, exp_rk);
        check($sformatf("k%0d_dp_en%0d", klen, r), dp_en, 1);
        check($sformatf("k%0d_dp_mix%0d", klen, r), dp_mix, (r != 0 && r != nr));
        check($sformatf("k%0d_dp_load%0d", klen, r), dp_load, (r == 0));
        check($sformatf("k%0d_dp_inv%0d", klen, r), dp_inv, eff_dec);
        check($sformatf("k%0d_busy%0d", klen, r), busy, 1);
        check($sformatf("k%0d_ready_busy%0d", klen, r), hif.in_ready, 0);
      end
      r++;
      tick();
      edges++;
    end
    check("latency_edges", edges, nr + 2);
    check("rounds_seen", r, nr + 1);
    check("done_dp_en", dp_en, 0);
    check("done_busy", busy, 1);
    for (int i = 0; i < stall; i++) begin
      check($sformatf("stall_valid%0d", i), hif.out_valid, 1);
      check($sformatf("stall_ready%0d", i), hif.in_ready, 0);
      tick();
    end
    key_ready     = 1'b1;
    hif.out_ready = 1'b1;
    tick();
    check("idle_out_valid", hif.out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", hif.in_ready, 1);
    check("idle_rk_idx", rk_idx, 0);
  endtask

  initial begin
    int n;
    int seen;
    hif.in_valid  = 1'b0;
    hif.in_klen   = 2'd0;
    hif.in_dec    = 1'b0;
    hif.out_ready = 1'b1;

    // 1: reset
    rst = 1'b1;
    key_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", hif.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", hif.out_valid, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_rnd", rnd, 0);
    check("rst_err", hif.err, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", hif.in_ready, 1);

    // 2: AES-128 encrypt, out_ready high
    run_block(2'd0, 1'b0, 10, 0, 1'b0);

    // 3: AES-256 decrypt (reversed only when decryption is built in), key drops mid-block
    run_block(2'd2, 1'b1, 14, 0, 1'b1);

    // 4: illegal key length
    hif.in_klen  = 2'd3;
    hif.in_valid = 1'b1;
    tick();
    hif.in_valid = 1'b0;
    check("illegal_err", hif.err, 1);
    check("illegal_busy", busy, 0);
    check("illegal_in_ready", hif.in_ready, 1);
    tick();
    check("illegal_err_cleared", hif.err, 0);
    check("illegal_busy2", busy, 0);

    // 5: AES-128 with 5 cycles of result back-pressure, then AES-192
    run_block(2'd0, 1'b0, 10, 5, 1'b0);
    run_block(2'd1, 1'b0, 12, 0, 1'b0);

    // 6: reset at rnd 5 of an AES-192 block
    hif.in_klen  = 2'd1;
    hif.in_dec   = 1'b0;
    hif.in_valid = 1'b1;
    tick();
    hif.in_valid = 1'b0;
    n = 0;
    while (rnd !== 4'd5 && n < 20) begin
      tick();
      n++;
    end
    check("mid_rst_reach_rnd5", rnd, 5);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rnd", rnd, 0);
    check("mid_rst_rk_idx", rk_idx, 0);
    check("mid_rst_dp", {dp_load, dp_en, dp_mix, dp_inv}, 0);
    check("mid_rst_out_valid", hif.out_valid, 0);
    check("mid_rst_in_ready", hif.in_ready, 0);
    check("mid_rst_state", dbg_state, IDLE);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hif.out_valid === 1'b1) seen++;
    end
    check("mid_rst_no_out_valid", seen, 0);
    check("mid_rst_idle_ready", hif.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
